// File: rtl/stim_pulse_sequencer_if.sv
// rtl/stim_pulse_sequencer_if.sv - control and status bundle for stim_pulse_sequencer
interface stim_pulse_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    logic              Start;
    logic              Stop;
    logic [NUM_CH-1:0] Ch_mask;
    logic [CNT_W-1:0]  Repeat;
    logic              Ack;
    logic [NUM_CH-1:0] Btn_n;
    logic              Busy;
    logic              Done;
    logic [CNT_W-1:0]  Pulses_sent;

    modport master (
        output Start, Stop, Ch_mask, Repeat, Ack,
        input  Btn_n, Busy, Done, Pulses_sent
    );

    modport slave (
        input  Start, Stop, Ch_mask, Repeat, Ack,
        output Btn_n, Busy, Done, Pulses_sent
    );
endinterface

// File: rtl/stim_pulse_sequencer.sv
// rtl/stim_pulse_sequencer.sv - active-low button pulse-train generator; STIM_WAIT_ACK_EN adds Ack-gated gaps
module stim_pulse_sequencer #(
    parameter int NUM_CH    = 2,
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 30,
    parameter int CNT_W     = 8
) (
    input logic                Clk,
    input logic                Reset,
    stim_pulse_sequencer_if.slave bus
);
    localparam int PH_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    typedef enum logic [1:0] {IDLE, PULSE, GAP, FIN} state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  rep_q, rep_d;
    logic [CNT_W-1:0]  pulses_q, pulses_d;
    logic [NUM_CH-1:0] btn_n_q, btn_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pulse_last, gap_last, gap_adv;

    assign pulse_last = (ph_cnt_q == PH_W'(PULSE_CYC - 1));
    assign gap_last   = (ph_cnt_q == PH_W'(GAP_CYC - 1));

`ifdef STIM_WAIT_ACK_EN
    // The gap counter parks on its last value until Ack is seen.
    assign gap_adv = gap_last && bus.Ack;
`else
    logic unused_ack;
    assign unused_ack = bus.Ack;
    assign gap_adv    = gap_last;
`endif

    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        mask_d   = mask_q;
        rep_d    = rep_q;
        pulses_d = pulses_q;
        btn_n_d  = '1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    mask_d   = bus.Ch_mask;
                    rep_d    = bus.Repeat;
                    pulses_d = '0;
                    ph_cnt_d = '0;
                    if (bus.Repeat == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PULSE;
                        busy_d  = 1'b1;
                        btn_n_d = ~bus.Ch_mask;
                    end
                end
            end
            PULSE: begin
                busy_d = 1'b1;
                if (pulse_last) begin
                    ph_cnt_d = '0;
                    pulses_d = pulses_q + CNT_W'(1);
                    state_d  = GAP;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                    btn_n_d  = ~mask_q;
                end
            end
            GAP: begin
                busy_d = 1'b1;
                if (gap_adv) begin
                    ph_cnt_d = '0;
                    if (pulses_q < rep_q) begin
                        state_d = PULSE;
                        btn_n_d = ~mask_q;
                    end else begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (!gap_last) begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Stop discards any pending latch or count update, keeping the partial count.
        if (bus.Stop) begin
            state_d  = IDLE;
            ph_cnt_d = '0;
            mask_d   = mask_q;
            rep_d    = rep_q;
            pulses_d = pulses_q;
            btn_n_d  = '1;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            ph_cnt_q <= '0;
            mask_q   <= '0;
            rep_q    <= '0;
            pulses_q <= '0;
            btn_n_q  <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_cnt_q <= ph_cnt_d;
            mask_q   <= mask_d;
            rep_q    <= rep_d;
            pulses_q <= pulses_d;
            btn_n_q  <= btn_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.Btn_n       = btn_n_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Pulses_sent = pulses_q;
endmodule

// File: tb/tb_stim_pulse_sequencer.sv
// tb/tb_stim_pulse_sequencer.sv - self-checking bench for stim_pulse_sequencer
module tb_stim_pulse_sequencer;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int P      = 1;
    localparam int G      = 30;
    localparam int PER    = P + G;

    logic Clk = 1'b0;
    logic Reset;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 Clk = ~Clk;

    stim_pulse_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    stim_pulse_sequencer #(
        .NUM_CH(NUM_CH), .PULSE_CYC(P), .GAP_CYC(G), .CNT_W(CNT_W)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    // Closed-form expectations; j counts edges after the accepting edge.
    function automatic logic [1:0] m_btn(input int j, input int r, input logic [1:0] m);
        return (j < r * PER && (j % PER) < P) ? ~m : 2'b11;
    endfunction

    function automatic int m_pulses(input int j, input int r);
        int n;
        if (j < P) return 0;
        n = (j - P) / PER + 1;
        return (n < r) ? n : r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic jitter_ack();
`ifdef STIM_WAIT_ACK_EN
        bus.Ack = 1'b1;
`else
        bus.Ack = 1'($urandom);
`endif
    endtask

    task automatic idle_check(input string tag, input int n, input int pulses);
        for (int k = 0; k < n; k++) begin
            check({tag, "/btn"},    32'(bus.Btn_n),       32'(2'b11));
            check({tag, "/busy"},   32'(bus.Busy),        32'(0));
            check({tag, "/done"},   32'(bus.Done),        32'(0));
            check({tag, "/pulses"}, 32'(bus.Pulses_sent), 32'(pulses));
            jitter_ack();
            step();
        end
    endtask

    task automatic run(input string tag, input logic [1:0] m, input int r,
                       input int abort_at, input bit by_reset, input int extra_at);
        int last;
        bit aborted;
        bus.Ch_mask = m;
        bus.Repeat  = CNT_W'(r);
        bus.Start   = 1'b1;
        step();
        bus.Start   = 1'b0;
        bus.Ch_mask = 2'($urandom);
        bus.Repeat  = CNT_W'($urandom);
        last    = r * PER + 1;
        aborted = 1'b0;
        for (int j = 0; j <= last && !aborted; j++) begin
            check({tag, "/btn"},    32'(bus.Btn_n),       32'(m_btn(j, r, m)));
            check({tag, "/busy"},   32'(bus.Busy),        32'(j < r * PER));
            check({tag, "/done"},   32'(bus.Done),        32'(j == r * PER));
            check({tag, "/pulses"}, 32'(bus.Pulses_sent), 32'(m_pulses(j, r)));
            bus.Start = (j == extra_at);
            jitter_ack();
            if (j == abort_at) begin
                if (by_reset) Reset = 1'b1;
                else bus.Stop = 1'b1;
                step();
                Reset     = 1'b0;
                bus.Stop  = 1'b0;
                bus.Start = 1'b0;
                check({tag, "/abort_btn"},    32'(bus.Btn_n),       32'(2'b11));
                check({tag, "/abort_busy"},   32'(bus.Busy),        32'(0));
                check({tag, "/abort_done"},   32'(bus.Done),        32'(0));
                check({tag, "/abort_pulses"}, 32'(bus.Pulses_sent),
                      32'(by_reset ? 0 : m_pulses(j, r)));
                aborted = 1'b1;
            end else begin
                step();
            end
        end
        bus.Start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset       = 1'b1;
        bus.Start   = 1'b0;
        bus.Stop    = 1'b0;
        bus.Ch_mask = 2'b00;
        bus.Repeat  = '0;
        bus.Ack     = 1'b0;
        step();
        step();
        Reset = 1'b0;
        step();
        check("reset/btn",    32'(bus.Btn_n),       32'(2'b11));
        check("reset/busy",   32'(bus.Busy),        32'(0));
        check("reset/done",   32'(bus.Done),        32'(0));
        check("reset/pulses", 32'(bus.Pulses_sent), 32'(0));

        run("plan8", 2'b10, 8, -1, 1'b0, -1);

        bus.Start = 1'b1;
        bus.Stop  = 1'b1;
        bus.Repeat = 8'd5;
        step();
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        idle_check("stop_start", 5, 8);

        run("zero", 2'b11, 0, -1, 1'b0, -1);
        idle_check("zero_idle", 5, 0);

        run("stop", 2'b10, 8, 70, 1'b0, -1);
        idle_check("stopped", 35, 3);
        run("rerun", 2'b10, 8, -1, 1'b0, -1);

        run("rst", 2'b11, 4, 31, 1'b1, 10);
        idle_check("after_rst", 5, 0);

        run("mask0", 2'b00, 3, -1, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            run("rand", 2'($urandom), int'($urandom_range(0, 6)), -1, 1'b0, -1);
        end

`ifdef STIM_WAIT_ACK_EN
        bus.Ack     = 1'b0;
        bus.Ch_mask = 2'b01;
        bus.Repeat  = 8'd2;
        bus.Start   = 1'b1;
        step();
        bus.Start = 1'b0;
        for (int j = 0; j < 50; j++) begin
            check("ack_wait/btn",    32'(bus.Btn_n),       32'(j == 0 ? 2'b10 : 2'b11));
            check("ack_wait/busy",   32'(bus.Busy),        32'(1));
            check("ack_wait/pulses", 32'(bus.Pulses_sent), 32'(j >= 1 ? 1 : 0));
            if (j < 49) step();
        end
        bus.Ack = 1'b1;
        step();
        check("ack_go/btn", 32'(bus.Btn_n), 32'(2'b10));
        for (int j = 51; j <= 81; j++) begin
            step();
            check("ack_tail/btn",  32'(bus.Btn_n), 32'(2'b11));
            check("ack_tail/done", 32'(bus.Done),  32'(j == 81));
        end
        check("ack_tail/pulses", 32'(bus.Pulses_sent), 32'(2));
        step();
`endif

        run("max", 2'($urandom), 255, -1, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
